// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_fwft : single-clock first-word-fall-through FIFO            |
// | dout always shows the head entry; push is ignored when full.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sync_fifo_fwft #(
  parameter int DW = 64,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/ddr_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ddr_burst_master : burst initiator toward the DDR user port, with     |
// | write/read staging FIFOs and one outstanding burst at a time.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 10
`endif

module ddr_burst_master #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_SIZE  = `ADDR_SIZE,
  parameter int LEN_WIDTH  = `LEN_WIDTH,
  parameter int FIFO_AW    = 9
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_SIZE-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_done,
  output logic                  err_overrun,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] burst_write_data,
  output logic [ADDR_SIZE-1:0]  burst_write_addr,
  output logic [LEN_WIDTH-1:0]  burst_write_len,
  output logic                  burst_write_req,
  input  logic                  burst_write_valid,
  input  logic                  burst_write_finish,
  input  logic [DATA_WIDTH-1:0] burst_read_data,
  output logic [ADDR_SIZE-1:0]  burst_read_addr,
  output logic [LEN_WIDTH-1:0]  burst_read_len,
  output logic                  burst_read_req,
  input  logic                  burst_read_valid,
  input  logic                  burst_read_finish
);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR_REQ  = ST_WR_REQ,
    WR_DATA = ST_WR_DATA,
    RD_REQ  = ST_RD_REQ,
    RD_DATA = ST_RD_DATA,
    DONE    = ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH:0]    beat_q, beat_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] wfifo_head;
  logic                  wfifo_full, wfifo_empty, wfifo_pop;
  logic [FIFO_AW:0]      wfifo_count;
  logic                  rfifo_full, rfifo_empty, rfifo_push;
  logic [FIFO_AW:0]      rfifo_count;

  logic wr_phase, rd_phase, beat_room, wr_elig, rd_elig;

  sync_fifo_fwft #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_wfifo (
    .clk(user_clk), .rst(user_rst),
    .push(wvalid), .din(wdata),
    .pop(wfifo_pop), .dout(wfifo_head),
    .full(wfifo_full), .empty(wfifo_empty), .count(wfifo_count)
  );

  sync_fifo_fwft #(.DW(DATA_WIDTH), .AW(FIFO_AW)) u_rfifo (
    .clk(user_clk), .rst(user_rst),
    .push(rfifo_push), .din(burst_read_data),
    .pop(rready), .dout(rdata),
    .full(rfifo_full), .empty(rfifo_empty), .count(rfifo_count)
  );

  assign wr_phase  = (state_q == WR_REQ) || (state_q == WR_DATA);
  assign rd_phase  = (state_q == RD_REQ) || (state_q == RD_DATA);
  assign beat_room = beat_q < {1'b0, len_q};
  assign wr_elig   = 32'(wfifo_count) >= 32'(cmd_len);
  assign rd_elig   = (32'(DEPTH) - 32'(rfifo_count)) >= 32'(cmd_len);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    err_d      = err_q;
    cmd_ready  = 1'b0;
    cmd_done   = 1'b0;
    wfifo_pop  = 1'b0;
    rfifo_push = 1'b0;

    // Beats are honoured in the REQ state too: a responder may start streaming
    // in the same cycle it first sees req.
    if (wr_phase && burst_write_valid) begin
      if (beat_room && !wfifo_empty) begin
        wfifo_pop = 1'b1;
        beat_d    = beat_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (rd_phase && burst_read_valid) begin
      if (beat_room && !rfifo_full) begin
        rfifo_push = 1'b1;
        beat_d     = beat_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        cmd_ready = cmd_valid && !user_rst && (cmd_rw ? wr_elig : rd_elig);
        if (cmd_ready) begin
          addr_d = cmd_addr & ~ADDR_SIZE'(7);
          len_d  = cmd_len;
          beat_d = '0;
          if (cmd_len == '0) state_d = DONE;
          else               state_d = cmd_rw ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (burst_write_finish)     state_d = DONE;
        else if (burst_write_valid) state_d = WR_DATA;
      end
      WR_DATA: if (burst_write_finish) state_d = DONE;
      RD_REQ: begin
        if (burst_read_finish)      state_d = DONE;
        else if (burst_read_valid)  state_d = RD_DATA;
      end
      RD_DATA: if (burst_read_finish) state_d = DONE;
      DONE: begin
        cmd_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign err_overrun      = err_q;
  assign wready           = !wfifo_full && !user_rst;
  assign rvalid           = !rfifo_empty;
  assign burst_write_req  = (state_q == WR_REQ);
  assign burst_read_req   = (state_q == RD_REQ);
  assign burst_write_addr = addr_q;
  assign burst_read_addr  = addr_q;
  assign burst_write_len  = len_q;
  assign burst_read_len   = len_q;
  assign burst_write_data = (wr_phase && !beat_room) ? '0 : wfifo_head;
endmodule
`default_nettype wire
